// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the iteration-counter width helper.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes and for
// the sign correction applied to results.
module mdu_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative shift-add multiply / restoring divide with HI/LO registers.
// Define MULTDIV_DIV_EN to include the div/divu datapath.
module multdiv_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = clog2(WIDTH);

    mdu_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic                   neg_p_q, neg_p_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;

    logic                   op_signed, op_div, op_legal;
    logic [WIDTH-1:0]       mag_a, mag_b;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_step;

    assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign op_div    = (op == MDU_DIV)  || (op == MDU_DIVU);

`ifdef MULTDIV_DIV_EN
    logic                   neg_r_q, neg_r_d;
    logic                   div_q, div_d;
    logic                   bzero_q, bzero_d;
    logic [WIDTH-1:0]       dvd_q, dvd_d;
    logic [WIDTH-1:0]       quo_fix, rem_fix;
    logic [WIDTH:0]         rem_sh, diff;
    logic [2*WIDTH-1:0]     div_step;

    assign op_legal = 1'b1;
`else
    assign op_legal = ~op_div;
`endif

    mdu_signfix #(.W(WIDTH)) u_mag_a (
        .val_i (a),
        .neg_i (op_signed & a[WIDTH-1]),
        .res_o (mag_a)
    );

    mdu_signfix #(.W(WIDTH)) u_mag_b (
        .val_i (b),
        .neg_i (op_signed & b[WIDTH-1]),
        .res_o (mag_b)
    );

    mdu_signfix #(.W(2*WIDTH)) u_fix_prod (
        .val_i (acc_q),
        .neg_i (neg_p_q),
        .res_o (prod_fix)
    );

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULTDIV_DIV_EN
    mdu_signfix #(.W(WIDTH)) u_fix_quo (
        .val_i (acc_q[WIDTH-1:0]),
        .neg_i (neg_p_q),
        .res_o (quo_fix)
    );

    mdu_signfix #(.W(WIDTH)) u_fix_rem (
        .val_i (acc_q[2*WIDTH-1:WIDTH]),
        .neg_i (neg_r_q),
        .res_o (rem_fix)
    );

    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, opnd_q};
    assign div_step = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b1};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        neg_p_d = neg_p_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULTDIV_DIV_EN
        neg_r_d = neg_r_q;
        div_d   = div_q;
        bzero_d = bzero_q;
        dvd_d   = dvd_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && op_legal) begin
                    state_d = CALC;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    neg_p_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
                    opnd_d  = mag_a;
`ifdef MULTDIV_DIV_EN
                    neg_r_d = op_signed & a[WIDTH-1];
                    div_d   = op_div;
                    bzero_d = (b == '0);
                    dvd_d   = a;
                    if (op_div) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end
`endif
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            CALC: begin
                acc_d = mul_step;
`ifdef MULTDIV_DIV_EN
                if (div_q) acc_d = div_step;
`endif
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                state_d      = IDLE;
                done_d       = 1'b1;
                {hi_d, lo_d} = prod_fix;
`ifdef MULTDIV_DIV_EN
                if (div_q) begin
                    if (bzero_q) begin
                        hi_d = dvd_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            neg_p_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULTDIV_DIV_EN
            neg_r_q <= 1'b0;
            div_q   <= 1'b0;
            bzero_q <= 1'b0;
            dvd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            neg_p_q <= neg_p_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULTDIV_DIV_EN
            neg_r_q <= neg_r_d;
            div_q   <= div_d;
            bzero_q <= bzero_d;
            dvd_q   <= dvd_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
